// File: rtl/boot_loader.sv
// Byte-stream image loader: assembles 16-bit words (high byte first), writes them to
// memory, verifies an XOR checksum, then hands the memory write port to the CPU.
module boot_loader #(
    parameter int MAX_WORDS  = 128,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_in,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic                  load_error,
    output logic [7:0]            words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHECK = 3'd5,
        S_RUN   = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    state_t                  state_r;
    logic [7:0]              n_r;
    logic [7:0]              idx_r;
    logic [7:0]              csum_r;
    logic [7:0]              hi_r;
    logic                    in_ready_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [15:0]             mem_in_r;
    logic                    cpu_run_r;
    logic                    load_done_r;
    logic                    load_error_r;
    logic [7:0]              words_loaded_r;
    logic                    accept_s;
    logic [7:0]              idx_next_s;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign accept_s   = in_valid && in_ready_r;
    assign idx_next_s = idx_r + 8'd1;

    // Loader FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            n_r            <= 8'd0;
            idx_r          <= 8'd0;
            csum_r         <= 8'd0;
            hi_r           <= 8'd0;
            in_ready_r     <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= '0;
            mem_in_r       <= 16'd0;
            cpu_run_r      <= 1'b0;
            load_done_r    <= 1'b0;
            load_error_r   <= 1'b0;
            words_loaded_r <= 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    in_ready_r <= 1'b1;
                    state_r    <= S_COUNT;
                end
                S_COUNT: begin
                    if (accept_s) begin
                        if ((in_data == 8'd0) || (in_data > MAX_N)) begin
                            in_ready_r   <= 1'b0;
                            load_error_r <= 1'b1;
                            state_r      <= S_ERROR;
                        end else begin
                            n_r     <= in_data;
                            csum_r  <= in_data;
                            state_r <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (accept_s) begin
                        hi_r    <= in_data;
                        csum_r  <= csum_fold(csum_r, in_data);
                        state_r <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept_s) begin
                        mem_in_r   <= {hi_r, in_data};
                        mem_addr_r <= {idx_r[ADDR_WIDTH-2:0], 1'b0};
                        mem_we_r   <= 1'b1;
                        csum_r     <= csum_fold(csum_r, in_data);
                        in_ready_r <= 1'b0;
                        state_r    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    mem_we_r   <= 1'b0;
                    in_ready_r <= 1'b1;
                    idx_r      <= idx_next_s;
                    if (words_loaded_r < n_r) begin
                        words_loaded_r <= words_loaded_r + 8'd1;
                    end
                    if (idx_next_s == n_r) begin
                        state_r <= S_CHECK;
                    end else begin
                        state_r <= S_HI;
                    end
                end
                S_CHECK: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (in_data == csum_r) begin
                            cpu_run_r   <= 1'b1;
                            load_done_r <= 1'b1;
                            state_r     <= S_RUN;
                        end else begin
                            load_error_r <= 1'b1;
                            state_r      <= S_ERROR;
                        end
                    end
                end
                S_RUN: begin
                    in_ready_r <= 1'b0;
                    mem_we_r   <= 1'b0;
                end
                S_ERROR: begin
                    in_ready_r <= 1'b0;
                    mem_we_r   <= 1'b0;
                end
                default: begin
                    in_ready_r   <= 1'b0;
                    mem_we_r     <= 1'b0;
                    load_error_r <= 1'b1;
                    state_r      <= S_ERROR;
                end
            endcase
        end
    end

    // Once running, the CPU owns the memory write port with no added latency.
    always_comb begin
        if (cpu_run_r) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_in   = cpu_data;
        end else begin
            mem_we   = mem_we_r;
            mem_addr = mem_addr_r;
            mem_in   = mem_in_r;
        end
    end

    assign in_ready     = in_ready_r;
    assign cpu_run      = cpu_run_r;
    assign load_done    = load_done_r;
    assign load_error   = load_error_r;
    assign words_loaded = words_loaded_r;

endmodule
